// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller. Validates each load/store
// against the data-memory window, drives the memory ports for WAIT_CYCLES
// cycles while freezing the pipeline, and captures load data for write-back.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024,
  parameter int MEM_BYTES   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  input  logic        req_r_en,
  input  logic        req_w_en,
  output logic        freeze,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        addr_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_data_in,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] LO_ADDR   = 32'(BASE_ADDR);
  localparam logic [31:0] HI_ADDR   = 32'(BASE_ADDR + MEM_BYTES - 4);
  localparam logic [3:0]  CNT_START = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_load_q, is_load_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        req_s;
  logic        legal_s;

  // Request decode and unsigned window / word-alignment check
  always_comb begin
    req_s   = req_r_en | req_w_en;
    legal_s = (req_adr >= LO_ADDR) && (req_adr <= HI_ADDR) &&
              (req_adr[1:0] == 2'b00);
  end

  // State, counter, request latches and load-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      adr_q     <= 32'd0;
      wdata_q   <= 32'd0;
      is_load_q <= 1'b0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      is_load_q <= is_load_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next-state logic: accept legal requests, count wait cycles, capture loads
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    is_load_d = is_load_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (req_s && legal_s) begin
          adr_d     = req_adr;
          wdata_d   = req_wdata;
          // A request with both enables set is handled as a load
          is_load_d = req_r_en;
          cnt_d     = CNT_START;
          state_d   = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (is_load_q) begin
            rd_data_d = mem_data;
          end else begin
            rd_data_d = rd_data_q;
          end
          state_d = DONE;
        end else begin
          state_d = ACCESS;
        end
      end
      DONE: begin
        // The request inputs still hold the frozen instruction; ignore them
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode: freeze/addr_err react to the request in IDLE, enables only in ACCESS
  always_comb begin
    freeze   = 1'b0;
    addr_err = 1'b0;
    done     = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          freeze   = legal_s;
          addr_err = ~legal_s;
        end else begin
          freeze   = 1'b0;
          addr_err = 1'b0;
        end
      end
      ACCESS: begin
        freeze   = 1'b1;
        mem_r_en = is_load_q;
        mem_w_en = ~is_load_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        freeze = 1'b0;
      end
    endcase
  end

  assign mem_adr     = adr_q;
  assign mem_data_in = wdata_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed sequence, byte-addressed
// big-endian memory model updated on the falling edge, and a scoreboard queue
// holding the rd_data expected at each done pulse.
module tb_mem_access_ctrl;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_adr, req_wdata;
  logic        req_r_en, req_w_en;
  logic        freeze, done, addr_err, mem_r_en, mem_w_en;
  logic [31:0] rd_data, mem_adr, mem_data_in;
  logic [31:0] mem_data;

  logic [7:0]  mem [0:4095];
  logic [31:0] sb_q[$];
  logic [31:0] exp_rd_model;
  int          checks = 0;
  int          errors = 0;

  mem_access_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .BASE_ADDR(1024), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_adr(req_adr), .req_wdata(req_wdata), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .freeze(freeze), .done(done), .rd_data(rd_data), .addr_err(addr_err),
    .mem_adr(mem_adr), .mem_data_in(mem_data_in), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Data memory model: write then read on the falling edge
  always @(negedge clk) begin
    int a;
    a = int'(mem_adr[11:0]);
    if (mem_w_en) begin
      mem[a]   = mem_data_in[31:24];
      mem[a+1] = mem_data_in[23:16];
      mem[a+2] = mem_data_in[15:8];
      mem[a+3] = mem_data_in[7:0];
    end
    mem_data = word_at(a);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_freeze"},   32'(freeze),   32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    check({tag, "_mem_r_en"}, 32'(mem_r_en), 32'd0);
    check({tag, "_mem_w_en"}, 32'(mem_w_en), 32'd0);
  endtask

  // Full legal access; exp_load is the word a load must return
  task automatic do_access(input string tag, input logic [31:0] adr, input logic [31:0] wdata,
                           input logic r, input logic w, input logic [31:0] exp_load);
    if (r) exp_rd_model = exp_load;
    sb_q.push_back(exp_rd_model);
    @(posedge clk); #1;
    req_adr = adr; req_wdata = wdata; req_r_en = r; req_w_en = w;
    @(negedge clk);
    check({tag, "_c0_freeze"},   32'(freeze),   32'd1);
    check({tag, "_c0_addr_err"}, 32'(addr_err), 32'd0);
    check({tag, "_c0_mem_en"},   {30'd0, mem_r_en, mem_w_en}, 32'd0);
    for (int i = 1; i <= WAIT_CYCLES; i++) begin
      @(posedge clk); @(negedge clk);
      check({tag, "_acc_freeze"},  32'(freeze),   32'd1);
      check({tag, "_acc_r_en"},    32'(mem_r_en), 32'(r));
      check({tag, "_acc_w_en"},    32'(mem_w_en), 32'(w & ~r));
      check({tag, "_acc_done"},    32'(done),     32'd0);
      check({tag, "_acc_adr"},     mem_adr,       adr);
      check({tag, "_acc_wdata"},   mem_data_in,   wdata);
    end
    @(posedge clk); @(negedge clk);
    check({tag, "_done"},        32'(done),     32'd1);
    check({tag, "_done_freeze"}, 32'(freeze),   32'd0);
    check({tag, "_done_err"},    32'(addr_err), 32'd0);
    check({tag, "_done_mem_en"}, {30'd0, mem_r_en, mem_w_en}, 32'd0);
    if (sb_q.size() > 0) check({tag, "_rd_data"}, rd_data, sb_q.pop_front());
    else check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    @(posedge clk); #1;
    req_r_en = 1'b0; req_w_en = 1'b0;
    @(negedge clk);
    check_quiet({tag, "_after"});
  endtask

  // Illegal request: addr_err pulse only
  task automatic do_illegal(input logic [31:0] adr);
    @(posedge clk); #1;
    req_adr = adr; req_wdata = 32'hCAFEF00D; req_r_en = 1'b1; req_w_en = 1'b0;
    @(negedge clk);
    check("illegal_addr_err", 32'(addr_err), 32'd1);
    check("illegal_freeze",   32'(freeze),   32'd0);
    check("illegal_mem_en",   {30'd0, mem_r_en, mem_w_en}, 32'd0);
    check("illegal_done",     32'(done),     32'd0);
    @(posedge clk); #1;
    req_r_en = 1'b0;
    @(negedge clk);
    check_quiet("illegal_after");
    check("illegal_rd_data", rd_data, exp_rd_model);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[1032], mem[1033], mem[1034], mem[1035]} = 32'hDEADBEEF;
    {mem[1048], mem[1049], mem[1050], mem[1051]} = 32'hA55AC33C;
    {mem[2044], mem[2045], mem[2046], mem[2047]} = 32'h11223344;
    exp_rd_model = 32'd0;
    rst = 1'b1; req_adr = 32'd0; req_wdata = 32'd0; req_r_en = 1'b0; req_w_en = 1'b0;

    // Power-on reset
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_quiet("por");
    check("por_rd_data", rd_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Load from 1032
    do_access("load1032", 32'd1032, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);

    // Store then load 1040; store keeps rd_data
    do_access("store1040", 32'd1040, 32'h12345678, 1'b0, 1'b1, 32'd0);
    check("store_mem_word", word_at(1040), 32'h12345678);
    do_access("load1040", 32'd1040, 32'd0, 1'b1, 1'b0, 32'h12345678);

    // Illegal addresses
    do_illegal(32'd1026);
    do_illegal(32'd1020);
    do_illegal(32'd2048);
    do_illegal(32'd2045);

    // Last legal word
    do_access("load2044", 32'd2044, 32'd0, 1'b1, 1'b0, 32'h11223344);

    // Both enables set: treated as load, memory untouched
    do_access("both1048", 32'd1048, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hA55AC33C);
    check("both_mem_unchanged", word_at(1048), 32'hA55AC33C);

    // Mid-run reset held 2 cycles
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_quiet("midrst");
    check("midrst_rd_data", rd_data, 32'd0);
    exp_rd_model = 32'd0;
    @(posedge clk); #1 rst = 1'b0;

    // Reset during cycle 1 of a load
    @(posedge clk); #1;
    req_adr = 32'd1032; req_r_en = 1'b1; req_w_en = 1'b0;
    @(negedge clk);
    check("abort_c0_freeze", 32'(freeze), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_c1_r_en", 32'(mem_r_en), 32'd1);
    @(posedge clk); #1 rst = 1'b0; req_r_en = 1'b0;
    @(negedge clk);
    check_quiet("abort_c2");
    check("abort_rd_data", rd_data, 32'd0);
    @(posedge clk); @(negedge clk);
    check_quiet("abort_c3");

    // Fresh load after abort
    do_access("reload1032", 32'd1032, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
